// File: rtl/mac_seq_pkg.sv
// Shared state type and MAC-pin constants for the dot-product sequencer.
package mac_seq_pkg;

  localparam int MAC_DATA_W  = 16;
  localparam int OUT_SEL_MAX = 24;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HOLD
  } state_t;

  // Offsets beyond the MAC's selectable range are pinned to the top slice.
  function automatic logic [5:0] clamp_out_sel(input logic [5:0] sel);
    return (sel > 6'(OUT_SEL_MAX)) ? 6'(OUT_SEL_MAX) : sel;
  endfunction

endpackage

// File: rtl/mac_dotprod_seq_if.sv
// Operand stream and result handshake between a frame source and the sequencer.
interface mac_dotprod_seq_if;
  import mac_seq_pkg::*;

  logic                  s_valid;
  logic                  s_ready;
  logic [MAC_DATA_W-1:0] s_oper;
  logic [MAC_DATA_W-1:0] s_coef;
  logic                  r_valid;
  logic                  r_ready;
  logic [MAC_DATA_W-1:0] r_data;

  modport master (
    output s_valid, s_oper, s_coef, r_ready,
    input  s_ready, r_valid, r_data
  );

  modport slave (
    input  s_valid, s_oper, s_coef, r_ready,
    output s_ready, r_valid, r_data
  );

endinterface

// File: rtl/mac_dotprod_seq.sv
// Frame sequencer for the eFPGA 16-bit math-block MAC: streams operand/coef
// pairs onto the MAC pins and captures the final MAC_OUT as a held result.
module mac_dotprod_seq
  import mac_seq_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic                  MAC_ACC_CLK,
  input  logic                  acc_ff_rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [5:0]            cfg_out_sel,
  input  logic                  cfg_rnd,
  input  logic                  cfg_sat,
  input  logic                  cfg_tc,
  mac_dotprod_seq_if.slave      bus,
  output logic [MAC_DATA_W-1:0] mac_oper,
  output logic [MAC_DATA_W-1:0] mac_coef,
  output logic                  mac_clk_en,
  output logic                  mac_acc_clear,
  output logic                  mac_acc_rnd,
  output logic [5:0]            mac_out_sel,
  output logic                  mac_acc_sat,
  output logic                  mac_tc,
  input  logic [MAC_DATA_W-1:0] mac_out,
  output logic                  busy
);

  localparam int DATA_W = MAC_DATA_W;

  state_t              state;
  logic [LEN_W-1:0]    rem;
  logic                first;
  logic                drain_last;
  logic                rnd_q;
  logic                s_ready_q;
  logic                r_valid_q;
  logic [DATA_W-1:0]   r_data_q;
  logic                fire;

  assign fire        = bus.s_valid & s_ready_q & ~abort;
  assign bus.s_ready = s_ready_q;
  assign bus.r_valid = r_valid_q;
  assign bus.r_data  = r_data_q;

  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      state       <= IDLE;
      rem         <= '0;
      first       <= 1'b0;
      drain_last  <= 1'b0;
      rnd_q       <= 1'b0;
      s_ready_q   <= 1'b0;
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
      busy        <= 1'b0;
      mac_out_sel <= '0;
      mac_acc_sat <= 1'b0;
      mac_tc      <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      rem         <= '0;
      first       <= 1'b0;
      drain_last  <= 1'b0;
      rnd_q       <= 1'b0;
      s_ready_q   <= 1'b0;
      r_valid_q   <= 1'b0;
      busy        <= 1'b0;
      mac_out_sel <= '0;
      mac_acc_sat <= 1'b0;
      mac_tc      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && cfg_len != '0) begin
            state       <= RUN;
            rem         <= cfg_len;
            first       <= 1'b1;
            rnd_q       <= cfg_rnd;
            s_ready_q   <= 1'b1;
            busy        <= 1'b1;
            mac_out_sel <= clamp_out_sel(cfg_out_sel);
            mac_acc_sat <= cfg_sat;
            mac_tc      <= cfg_tc;
          end
        end
        RUN: begin
          if (fire) begin
            first <= 1'b0;
            rem   <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) begin
              state      <= DRAIN;
              s_ready_q  <= 1'b0;
              drain_last <= 1'b0;
            end
          end
        end
        // First DRAIN cycle presents the last beat; MAC_OUT is final in the second.
        DRAIN: begin
          if (drain_last) begin
            r_data_q   <= mac_out;
            r_valid_q  <= 1'b1;
            drain_last <= 1'b0;
            state      <= HOLD;
          end else begin
            drain_last <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.r_ready) begin
            r_valid_q   <= 1'b0;
            busy        <= 1'b0;
            rnd_q       <= 1'b0;
            mac_out_sel <= '0;
            mac_acc_sat <= 1'b0;
            mac_tc      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The first beat of a frame either clears or preloads the rounding constant.
  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      mac_oper      <= '0;
      mac_coef      <= '0;
      mac_clk_en    <= 1'b0;
      mac_acc_clear <= 1'b0;
      mac_acc_rnd   <= 1'b0;
    end else begin
      mac_clk_en    <= fire;
      mac_acc_clear <= fire & first & ~rnd_q;
      mac_acc_rnd   <= fire & first & rnd_q;
      if (fire) begin
        mac_oper <= bus.s_oper;
        mac_coef <= bus.s_coef;
      end
    end
  end

endmodule

// File: tb/tb_mac_dotprod_seq.sv
// Bench for mac_dotprod_seq paired with a behavioural 16-bit MAC; results are
// predicted from the accepted beats of each frame and the frame configuration.
module tb_mac_dotprod_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  cfg_len = '0;
  logic [5:0]  cfg_out_sel = '0;
  logic        cfg_rnd = 1'b0;
  logic        cfg_sat = 1'b0;
  logic        cfg_tc = 1'b0;
  logic [15:0] mac_oper, mac_coef, mac_out;
  logic        mac_clk_en, mac_acc_clear, mac_acc_rnd, mac_acc_sat, mac_tc;
  logic [5:0]  mac_out_sel;
  logic        busy;

  mac_dotprod_seq_if bus();

  mac_dotprod_seq #(.LEN_W(10)) dut (
    .MAC_ACC_CLK   (clk),
    .acc_ff_rstn   (rstn),
    .start         (start),
    .abort         (abort),
    .cfg_len       (cfg_len),
    .cfg_out_sel   (cfg_out_sel),
    .cfg_rnd       (cfg_rnd),
    .cfg_sat       (cfg_sat),
    .cfg_tc        (cfg_tc),
    .bus           (bus),
    .mac_oper      (mac_oper),
    .mac_coef      (mac_coef),
    .mac_clk_en    (mac_clk_en),
    .mac_acc_clear (mac_acc_clear),
    .mac_acc_rnd   (mac_acc_rnd),
    .mac_out_sel   (mac_out_sel),
    .mac_acc_sat   (mac_acc_sat),
    .mac_tc        (mac_tc),
    .mac_out       (mac_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit          in_frame = 0;
  bit          exp_pending = 0;
  logic [15:0] exp_result = '0;
  int          cur_sel = 0;
  bit          cur_rnd = 0, cur_sat = 0, cur_tc = 0;
  logic [15:0] stim_oper[$], stim_coef[$];
  logic [15:0] q_oper[$], q_coef[$];
  int          beat_count = 0;
  bit          fired_prev = 0, prev_first = 0;
  logic [15:0] prev_oper = '0, prev_coef = '0;
  logic        first_clear_seen = 1'b0, first_rnd_seen = 1'b0;

  function automatic longint mul16(input logic [15:0] a, input logic [15:0] b, input bit tc);
    if (tc) return longint'($signed(a)) * longint'($signed(b));
    return longint'(a) * longint'(b);
  endfunction

  function automatic longint round_half(input int sel);
    if (sel == 0) return 0;
    return longint'(1) << (sel - 1);
  endfunction

  function automatic logic [15:0] out_slice(input longint acc, input int sel, input bit sat, input bit tc);
    longint v;
    v = acc >>> sel;
    if (sat) begin
      if (tc) begin
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
      end else begin
        if (v > 65535) v = 65535;
        else if (v < 0) v = 0;
      end
    end
    return v[15:0];
  endfunction

  // Stand-in for the math block: accumulator updates on the pins of the previous cycle.
  longint mac_acc = 0;
  always @(posedge clk) begin
    if (mac_clk_en) begin
      if (mac_acc_clear)
        mac_acc <= mul16(mac_oper, mac_coef, mac_tc);
      else if (mac_acc_rnd)
        mac_acc <= mul16(mac_oper, mac_coef, mac_tc) + round_half(int'(mac_out_sel));
      else
        mac_acc <= mac_acc + mul16(mac_oper, mac_coef, mac_tc);
    end
  end
  assign mac_out = out_slice(mac_acc, int'(mac_out_sel), mac_acc_sat, mac_tc);

  function automatic logic [15:0] model_result();
    longint sum = 0;
    foreach (q_oper[i]) sum += mul16(q_oper[i], q_coef[i], cur_tc);
    if (cur_rnd) sum += round_half(cur_sel);
    return out_slice(sum, cur_sel, cur_sat, cur_tc);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      fired_prev = 0;
    end else begin
      checkOutput("clk_en", 32'(mac_clk_en), 32'(fired_prev));
      checkOutput("clear_rnd_exclusive", 32'(mac_acc_clear & mac_acc_rnd), 0);
      if (fired_prev) begin
        checkOutput("mac_oper", 32'(mac_oper), 32'(prev_oper));
        checkOutput("mac_coef", 32'(mac_coef), 32'(prev_coef));
        checkOutput("acc_clear", 32'(mac_acc_clear), 32'(prev_first & ~cur_rnd));
        checkOutput("acc_rnd", 32'(mac_acc_rnd), 32'(prev_first & cur_rnd));
        if (prev_first) begin
          first_clear_seen = mac_acc_clear;
          first_rnd_seen   = mac_acc_rnd;
        end
      end else begin
        checkOutput("acc_clear_idle", 32'(mac_acc_clear), 0);
        checkOutput("acc_rnd_idle", 32'(mac_acc_rnd), 0);
      end
      checkOutput("busy", 32'(busy), 32'(in_frame));
      if (in_frame) begin
        checkOutput("out_sel", 32'(mac_out_sel), 32'(cur_sel));
        checkOutput("acc_sat", 32'(mac_acc_sat), 32'(cur_sat));
        checkOutput("tc", 32'(mac_tc), 32'(cur_tc));
      end
      if (!exp_pending) checkOutput("r_valid_idle", 32'(bus.r_valid), 0);
      else if (bus.r_valid) checkOutput("r_data_model", 32'(bus.r_data), 32'(exp_result));
      fired_prev = bus.s_valid & bus.s_ready & ~abort;
      if (fired_prev) begin
        prev_first = (beat_count == 0);
        prev_oper  = bus.s_oper;
        prev_coef  = bus.s_coef;
        beat_count++;
      end
    end
  end

  task automatic startFrame(input int len, input int sel, input bit rnd, input bit sat, input bit tc);
    cfg_len = 10'(len); cfg_out_sel = 6'(sel);
    cfg_rnd = rnd; cfg_sat = sat; cfg_tc = tc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cur_sel = sel; cur_rnd = rnd; cur_sat = sat; cur_tc = tc;
    beat_count = 0;
    q_oper.delete(); q_coef.delete();
    in_frame = (len != 0);
  endtask

  task automatic sendBeat(input logic [15:0] o, input logic [15:0] c, input int gap);
    bit ok = 0;
    repeat (gap) begin
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1; bus.s_oper = o; bus.s_coef = c;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    if (ok) begin
      q_oper.push_back(o); q_coef.push_back(c);
    end else begin
      n_checks++; n_fail++;
      $display("[TB] FAIL beat_accept: actual s_ready=0 required 1");
    end
  endtask

  task automatic applyStimulus(input int len, input int sel, input bit rnd, input bit sat, input bit tc,
                               input int gap, input int hold, input logic [15:0] exp_lit, input string name);
    int lat;
    startFrame(len, sel, rnd, sat, tc);
    for (int i = 0; i < len; i++) sendBeat(stim_oper[i], stim_coef[i], (i == 0) ? 0 : gap);
    exp_result  = model_result();
    exp_pending = 1;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.r_valid) break;
    end
    checkOutput({name, "_latency"}, 32'(lat), 3);
    checkOutput({name, "_r_data"}, 32'(bus.r_data), 32'(exp_lit));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      cfg_len = 10'd2;
      start = (h == 1);
      @(negedge clk);
      checkOutput({name, "_hold_valid"}, 32'(bus.r_valid), 1);
      checkOutput({name, "_hold_data"}, 32'(bus.r_data), 32'(exp_lit));
    end
    @(posedge clk); #1;
    cfg_len = 10'd2; start = 1'b1; bus.r_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bus.r_ready = 1'b0;
    exp_pending = 0; in_frame = 0;
    @(negedge clk);
    checkOutput({name, "_idle_after"}, 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_oper = '0; bus.s_coef = '0; bus.r_ready = 1'b0;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_s_ready", 32'(bus.s_ready), 0);
    checkOutput("reset_r_valid", 32'(bus.r_valid), 0);
    checkOutput("reset_r_data", 32'(bus.r_data), 0);
    checkOutput("reset_clk_en", 32'(mac_clk_en), 0);
    checkOutput("reset_mac_oper", 32'(mac_oper), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    stim_oper = '{16'd2, 16'd3, 16'd4}; stim_coef = '{16'd5, 16'd6, 16'd7};
    applyStimulus(3, 0, 0, 0, 0, 0, 0, 16'h0038, "dot3");
    checkOutput("dot3_first_clear", 32'(first_clear_seen), 1);
    checkOutput("dot3_first_rnd", 32'(first_rnd_seen), 0);

    stim_oper = '{16'hFFFF}; stim_coef = '{16'h0003};
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 16'hFFFD, "tc_neg");

    stim_oper = '{16'h0018}; stim_coef = '{16'h0001};
    applyStimulus(1, 4, 1, 0, 0, 0, 0, 16'h0002, "round");
    checkOutput("round_first_clear", 32'(first_clear_seen), 0);
    checkOutput("round_first_rnd", 32'(first_rnd_seen), 1);

    stim_oper = '{16'hFFFF, 16'hFFFF}; stim_coef = '{16'hFFFF, 16'hFFFF};
    applyStimulus(2, 0, 0, 1, 0, 0, 0, 16'hFFFF, "sat_u");

    stim_oper = '{16'h8000, 16'h8000}; stim_coef = '{16'h7FFF, 16'h7FFF};
    applyStimulus(2, 0, 0, 1, 1, 0, 1, 16'h8000, "sat_s");

    stim_oper = '{16'd1, 16'd3, 16'd5}; stim_coef = '{16'd2, 16'd4, 16'd6};
    applyStimulus(3, 0, 0, 0, 0, 2, 5, 16'h002C, "gaps");

    // A zero-length start must leave the sequencer idle.
    startFrame(0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("len0_busy", 32'(busy), 0);
    checkOutput("len0_s_ready", 32'(bus.s_ready), 0);
    @(posedge clk); #1;

    startFrame(3, 0, 0, 0, 0);
    sendBeat(16'd7, 16'd8, 0);
    bus.s_valid = 1'b1; bus.s_oper = 16'd9; bus.s_coef = 16'd9; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; bus.s_valid = 1'b0; in_frame = 0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_s_ready", 32'(bus.s_ready), 0);
    checkOutput("abort_clk_en", 32'(mac_clk_en), 0);
    @(posedge clk); #1;
    stim_oper = '{16'd1}; stim_coef = '{16'd1};
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 16'h0001, "after_abort");

    startFrame(2, 0, 0, 0, 0);
    sendBeat(16'd5, 16'd5, 0);
    rstn = 1'b0; in_frame = 0;
    #1;
    checkOutput("midreset_busy", 32'(busy), 0);
    checkOutput("midreset_s_ready", 32'(bus.s_ready), 0);
    checkOutput("midreset_clk_en", 32'(mac_clk_en), 0);
    checkOutput("midreset_r_data", 32'(bus.r_data), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 16'h0001, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
